msrv32_wb_stage: RTL
====================

Name: msrv32_wb_stage

Overview:
- Write-back pipeline stage that drives the write port of the integer register file.
- Accepts one retiring instruction per cycle from the execute stage and selects its result source.
- For loads, waits on the data-memory response, then sign/zero-extends and aligns the data.
- Presents a registered one-cycle write (address, data, enable) to the register file.
- Stalls upstream while a load is outstanding; aborts a load that times out.

Parameters:
- LOAD_TIMEOUT, 16: maximum number of cycles spent in WAIT_LOAD without dmem_rvalid_in before abort. Legal range is 2 to 31.
- CNT_W, 5: width of the timeout counter. Must satisfy 2^CNT_W > LOAD_TIMEOUT.

Ports:
ms_riscv32_mp_clk_in  input  1  clock
ms_riscv32_mp_rst_in  input  1  synchronous active-high reset
valid_in  input  1  execute stage presents an instruction
ready_out  output  1  stage can accept; high only in IDLE
rd_addr_in  input  5  destination register
wr_en_in  input  1  instruction writes rd
wb_sel_in  input  3  result source: 0 ALU, 1 LOAD, 2 IMM (LUI), 3 PC+4, 4 CSR; 5-7 reserved, treated as ALU
alu_result_in  input  32  ALU result
imm_in  input  32  U-immediate
pc_plus_4_in  input  32  link value
csr_data_in  input  32  CSR read data
load_size_in  input  2  0 byte, 1 half, 2 word; 3 treated as word
load_unsigned_in  input  1  zero-extend when 1
load_addr_lsb_in  input  2  effective address bits [1:0]
dmem_rdata_in  input  32  data-memory read word
dmem_rvalid_in  input  1  read data valid
rd_addr_out  output  5  register-file write address
rd_out  output  32  register-file write data
wr_en_out  output  1  register-file write enable, one-cycle pulse
load_err_out  output  1  one-cycle pulse on load timeout

Behaviour:
- Reset is synchronous, on ms_riscv32_mp_rst_in at a clock edge. It forces:
  - state to IDLE and the counter to 0;
  - rd_addr_out=0, rd_out=0, wr_en_out=0, load_err_out=0;
  - ready_out=1 from the first cycle after reset;
  - all captured load attributes cleared.
- Reset during WAIT_LOAD abandons the load. No write occurs, and a later dmem_rvalid_in is ignored.
- ready_out is combinational: ready_out = (state==IDLE).
- Acceptance happens when valid_in && ready_out at a clock edge.
- Non-load accept (wb_sel_in != 1):
  - The next cycle shows wr_en_out = wr_en_in && (rd_addr_in != 0), with rd_out = the selected source and rd_addr_out = rd_addr_in. Latency is 1.
  - State stays IDLE, so back-to-back accepts give back-to-back writes.
- Load accept (wb_sel_in == 1):
  - Capture rd_addr, wr_en, size, unsigned and lsb; go to WAIT_LOAD; clear the counter.
  - The next cycle shows wr_en_out=0.
- WAIT_LOAD:
  - ready_out=0, and valid_in is ignored.
  - The counter increments each cycle without dmem_rvalid_in.
  - On dmem_rvalid_in: register the aligned data and go to IDLE. The next cycle shows wr_en_out = captured wr_en && rd != 0, and ready_out=1 in that same cycle.
  - If dmem_rvalid_in is absent and counter == LOAD_TIMEOUT-1: go to IDLE. The next cycle shows load_err_out=1 and wr_en_out=0.
  - If dmem_rvalid_in and the timeout coincide, rvalid wins and no error is raised.
- dmem_rvalid_in in IDLE is ignored.
- Load alignment:
  - byte: select dmem_rdata_in[8*lsb +: 8].
  - half: select dmem_rdata_in[16*lsb[1] +: 16]; lsb[0] is ignored.
  - word: whole word; lsb is ignored.
  - Extension: sign-extend from the MSB of the selected field unless unsigned, in which case zero-extend. Unsigned is ignored for word.
- Writes to x0: wr_en_out is never asserted with rd_addr_out=0.
- wr_en_out and load_err_out are never high together, and neither is held for more than one cycle per instruction.
- When wr_en_out=0, rd_out and rd_addr_out hold their last values.

Decomposition:
- Package msrv32_wb_pkg holds:
  - the WB_SEL_* codes (ALU=3'd0, LOAD=3'd1, IMM=3'd2, PC4=3'd3, CSR=3'd4);
  - the LD_SIZE_* codes (BYTE=2'd0, HALF=2'd1, WORD=2'd2);
  - the FSM state codes (IDLE, WAIT_LOAD).
- One combinational sub-module, msrv32_load_align: inputs rdata, size, unsigned, lsb; output the 32-bit extended value.

Test Plan:
- Reset, then an ALU accept with rd=5, alu=0x1234_5678 → one cycle later wr_en_out=1, rd_addr_out=5, rd_out=0x1234_5678. ready_out stays 1.
- Back-to-back: PC+4 accept (rd=1, 0x0000_0104) then LUI accept (rd=2, imm=0xABCD_E000) → writes on two consecutive cycles with those values.
- Load with dmem_rdata=0x80FF_7F01:
  - lb, lsb=3 → 0xFFFF_FF80.
  - lbu, lsb=3 → 0x0000_0080.
  - lh, lsb=2 → 0xFFFF_80FF.
  - rvalid is given 3 cycles after accept; ready_out stays low until the write cycle.
- Write to x0: ALU accept with rd=0 → wr_en_out stays 0. Load with rd=0 and rvalid → no write, no error.
- Timeout with LOAD_TIMEOUT=4 and no rvalid:
  - load_err_out pulses once after 4 WAIT_LOAD cycles, with no write.
  - A rerun with rvalid on the 4th cycle → write occurs and no error.
- Reset asserted in WAIT_LOAD, then rvalid after reset → no write, ready_out=1, all outputs 0.

Source files
------------

// File: rtl/msrv32_wb_pkg.sv
// Shared encodings for the write-back stage: result-source select,
// load size, FSM state codes and the captured load context.
package msrv32_wb_pkg;

    localparam logic [2:0] WB_SEL_ALU  = 3'd0;
    localparam logic [2:0] WB_SEL_LOAD = 3'd1;
    localparam logic [2:0] WB_SEL_IMM  = 3'd2;
    localparam logic [2:0] WB_SEL_PC4  = 3'd3;
    localparam logic [2:0] WB_SEL_CSR  = 3'd4;

    localparam logic [1:0] LD_SIZE_BYTE = 2'd0;
    localparam logic [1:0] LD_SIZE_HALF = 2'd1;
    localparam logic [1:0] LD_SIZE_WORD = 2'd2;

    localparam logic [0:0] ST_IDLE      = 1'b0;
    localparam logic [0:0] ST_WAIT_LOAD = 1'b1;

    // Attributes of an outstanding load, held while waiting on memory
    typedef struct packed {
        logic [4:0] rd;
        logic       we;
        logic [1:0] size;
        logic       uns;
        logic [1:0] lsb;
    } ld_ctx_t;

    // Non-load result source; reserved codes fall back to the ALU result
    function automatic logic [31:0] wb_src_mux(
        input logic [2:0]  sel,
        input logic [31:0] alu,
        input logic [31:0] imm,
        input logic [31:0] pc4,
        input logic [31:0] csr
    );
        logic [31:0] r;
        case (sel)
            WB_SEL_IMM: r = imm;
            WB_SEL_PC4: r = pc4;
            WB_SEL_CSR: r = csr;
            default:    r = alu;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/msrv32_load_align.sv
// Load data alignment: picks the addressed byte/half out of the memory
// word and sign- or zero-extends it to 32 bits.
module msrv32_load_align
    import msrv32_wb_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [1:0]  lsb_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Field selection and extension; size 3 behaves as a word
    always_comb begin
        case (lsb_i)
            2'd0:    byte_v = rdata_i[7:0];
            2'd1:    byte_v = rdata_i[15:8];
            2'd2:    byte_v = rdata_i[23:16];
            default: byte_v = rdata_i[31:24];
        endcase
        half_v = lsb_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (size_i)
            LD_SIZE_BYTE: data_o = {{24{~unsigned_i & byte_v[7]}}, byte_v};
            LD_SIZE_HALF: data_o = {{16{~unsigned_i & half_v[15]}}, half_v};
            default:      data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/msrv32_wb_stage.sv
// Write-back stage: selects the retiring result, waits on load data with a
// timeout, and drives a registered one-cycle register-file write.
module msrv32_wb_stage
    import msrv32_wb_pkg::*;
#(
    parameter int LOAD_TIMEOUT = 16,
    parameter int CNT_W        = 5
) (
    input  logic        ms_riscv32_mp_clk_in,
    input  logic        ms_riscv32_mp_rst_in,
    input  logic        valid_in,
    output logic        ready_out,
    input  logic [4:0]  rd_addr_in,
    input  logic        wr_en_in,
    input  logic [2:0]  wb_sel_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] imm_in,
    input  logic [31:0] pc_plus_4_in,
    input  logic [31:0] csr_data_in,
    input  logic [1:0]  load_size_in,
    input  logic        load_unsigned_in,
    input  logic [1:0]  load_addr_lsb_in,
    input  logic [31:0] dmem_rdata_in,
    input  logic        dmem_rvalid_in,
    output logic [4:0]  rd_addr_out,
    output logic [31:0] rd_out,
    output logic        wr_en_out,
    output logic        load_err_out
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOAD_TIMEOUT - 1);

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    ld_ctx_t          ctx_q, ctx_d;
    logic [4:0]       rd_addr_q, rd_addr_d;
    logic [31:0]      rd_q, rd_d;
    logic             we_q, we_d;
    logic             err_q, err_d;
    logic [31:0]      ld_data;

    msrv32_load_align u_align (
        .rdata_i    (dmem_rdata_in),
        .size_i     (ctx_q.size),
        .unsigned_i (ctx_q.uns),
        .lsb_i      (ctx_q.lsb),
        .data_o     (ld_data)
    );

    assign ready_out    = (state_q == ST_IDLE);
    assign rd_addr_out  = rd_addr_q;
    assign rd_out       = rd_q;
    assign wr_en_out    = we_q;
    assign load_err_out = err_q;

    // Next-state: accept in IDLE, wait/complete/abort loads in WAIT_LOAD.
    // Address/data only move on an actual write so they hold otherwise.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ctx_d     = ctx_q;
        rd_addr_d = rd_addr_q;
        rd_d      = rd_q;
        we_d      = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (valid_in) begin
                    if (wb_sel_in == WB_SEL_LOAD) begin
                        ctx_d.rd   = rd_addr_in;
                        ctx_d.we   = wr_en_in;
                        ctx_d.size = load_size_in;
                        ctx_d.uns  = load_unsigned_in;
                        ctx_d.lsb  = load_addr_lsb_in;
                        cnt_d      = '0;
                        state_d    = ST_WAIT_LOAD;
                    end else if (wr_en_in && (rd_addr_in != 5'd0)) begin
                        we_d      = 1'b1;
                        rd_addr_d = rd_addr_in;
                        rd_d      = wb_src_mux(wb_sel_in, alu_result_in, imm_in,
                                               pc_plus_4_in, csr_data_in);
                    end
                end
            end
            default: begin
                // rvalid takes priority over a coincident timeout
                if (dmem_rvalid_in) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    if (ctx_q.we && (ctx_q.rd != 5'd0)) begin
                        we_d      = 1'b1;
                        rd_addr_d = ctx_q.rd;
                        rd_d      = ld_data;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            ctx_q     <= '0;
            rd_addr_q <= '0;
            rd_q      <= '0;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ctx_q     <= ctx_d;
            rd_addr_q <= rd_addr_d;
            rd_q      <= rd_d;
            we_q      <= we_d;
            err_q     <= err_d;
        end
    end

endmodule
